// File: rtl/otter_pc_pkg.sv
// Shared types and constants for the OTTER program-counter / fetch block.
package otter_pc_pkg;

    typedef enum logic [2:0] {
        PLUS4  = 3'd0,
        JALR   = 3'd1,
        BRANCH = 3'd2,
        JAL    = 3'd3,
        MTVEC  = 3'd4,
        MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Only computed control-flow targets are alignment-checked; trap vectors are trusted.
    function automatic logic is_checked_src(pc_src_t src);
        return (src == JALR) || (src == BRANCH) || (src == JAL);
    endfunction

endpackage

// File: rtl/otter_pc_fetch_if.sv
// Instruction-fetch request handshake between the PC owner and instruction memory.
interface otter_pc_fetch_if;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;

    modport master (output fetch_valid, output fetch_addr, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_addr, output fetch_ready);
endinterface

// File: rtl/otter_pc_fetch_pc_next_mux.sv
// Next-PC select with misalignment trap substitution; purely combinational.
module pc_next_mux
    import otter_pc_pkg::*;
(
    input  logic [31:0] pc_i,
    input  pc_src_t     src_i,
    input  logic [31:0] jalr_i,
    input  logic [31:0] branch_i,
    input  logic [31:0] jal_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [31:0] target_o,
    output logic [31:0] raw_target_o,
    output logic        misaligned_o
);

    always_comb begin
        raw_target_o = pc_i + PC_STEP;
        case (src_i)
            JALR:    raw_target_o = jalr_i & ~32'd1;
            BRANCH:  raw_target_o = branch_i;
            JAL:     raw_target_o = jal_i;
            MTVEC:   raw_target_o = mtvec_i;
            MEPC:    raw_target_o = mepc_i;
            default: raw_target_o = pc_i + PC_STEP;
        endcase
        misaligned_o = is_checked_src(src_i) && (raw_target_o[1:0] != 2'b00);
        target_o     = misaligned_o ? mtvec_i : raw_target_o;
    end

endmodule

// File: rtl/otter_pc_fetch.sv
// OTTER PC register and fetch requester; buffers redirects that arrive while a request stalls.
//   state | meaning
//   BOOT  | first cycle after reset, no request, pc_write ignored
//   FETCH | request for PC outstanding, fetch_addr held until accepted
//   WAIT  | no request, waiting for the control unit to advance PC
module otter_pc_fetch
    import otter_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pc_write_i,
    input  pc_src_t                pc_source_i,
    input  logic [31:0]            jalr_i,
    input  logic [31:0]            branch_i,
    input  logic [31:0]            jal_i,
    input  logic [31:0]            mtvec_i,
    input  logic [31:0]            mepc_i,
    otter_pc_fetch_if.master       fetch,
    output logic [31:0]            pc_o,
    output logic [31:0]            pc_plus4_o,
    output logic                   addr_misaligned_o,
    output logic [31:0]            bad_target_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;
    logic         mis_q, mis_d;
    logic [31:0]  bad_q, bad_d;

    logic [31:0]  target;
    logic [31:0]  raw_target;
    logic         target_mis;

    pc_next_mux u_next_mux (
        .pc_i         (pc_q),
        .src_i        (pc_source_i),
        .jalr_i       (jalr_i),
        .branch_i     (branch_i),
        .jal_i        (jal_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .target_o     (target),
        .raw_target_o (raw_target),
        .misaligned_o (target_mis)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        mis_d      = 1'b0;
        bad_d      = bad_q;

        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (pc_write_i) begin
                    if (fetch.fetch_ready) begin
                        pc_d       = target;
                        pend_vld_d = 1'b0;
                    end else begin
                        // Last redirect while stalled wins.
                        pend_d     = target;
                        pend_vld_d = 1'b1;
                    end
                end else if (fetch.fetch_ready) begin
                    if (pend_vld_q) begin
                        pc_d       = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (pc_write_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (pc_write_i && (state_q != BOOT) && target_mis) begin
            mis_d = 1'b1;
            bad_d = raw_target;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            mis_q      <= 1'b0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            mis_q      <= mis_d;
            bad_q      <= bad_d;
        end
    end

    assign fetch.fetch_valid = (state_q == FETCH);
    assign fetch.fetch_addr  = pc_q;
    assign pc_o              = pc_q;
    assign pc_plus4_o        = pc_q + PC_STEP;
    assign addr_misaligned_o = mis_q;
    assign bad_target_o      = bad_q;

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Randomized and directed bench for otter_pc_fetch against a transaction-level PC model.
module tb_otter_pc_fetch;
    import otter_pc_pkg::*;

    logic        clk;
    logic        rst;
    logic        pc_write;
    pc_src_t     pc_source;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic [31:0] pc_o, pc_plus4;
    logic        misaligned;
    logic [31:0] bad_target;

    otter_pc_fetch_if fif ();

    otter_pc_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pc_write_i        (pc_write),
        .pc_source_i       (pc_source),
        .jalr_i            (jalr),
        .branch_i          (branch),
        .jal_i             (jal),
        .mtvec_i           (mtvec),
        .mepc_i            (mepc),
        .fetch             (fif),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4),
        .addr_misaligned_o (misaligned),
        .bad_target_o      (bad_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the fetch port should show after each clock.
    bit          m_boot;
    bit          m_req;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pend;
    bit          m_mis;
    logic [31:0] m_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_req  = 1'b0;
        m_pc   = 32'h0;
        m_pv   = 1'b0;
        m_pend = 32'h0;
        m_mis  = 1'b0;
        m_bad  = 32'h0;
    endtask

    task automatic model_edge(input bit pw, input int src, input bit rdy);
        logic [31:0] raw, tgt;
        bit          bad;
        case (src)
            1:       raw = jalr & ~32'd1;
            2:       raw = branch;
            3:       raw = jal;
            4:       raw = mtvec;
            5:       raw = mepc;
            default: raw = m_pc + 32'd4;
        endcase
        bad = (src >= 1) && (src <= 3) && ((raw % 4) != 0);
        tgt = bad ? mtvec : raw;
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else begin
            if (pw && bad) begin
                m_mis = 1'b1;
                m_bad = raw;
            end
            if (!m_req) begin
                if (pw) begin
                    m_pc  = tgt;
                    m_req = 1'b1;
                end
            end else if (pw && rdy) begin
                m_pc = tgt;
                m_pv = 1'b0;
            end else if (pw) begin
                m_pend = tgt;
                m_pv   = 1'b1;
            end else if (rdy) begin
                if (m_pv) begin
                    m_pc = m_pend;
                    m_pv = 1'b0;
                end else begin
                    m_req = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("valid", {31'd0, fif.fetch_valid}, {31'd0, m_req});
        check("addr", fif.fetch_addr, m_pc);
        check("pc", pc_o, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        check("bad_target", bad_target, m_bad);
    endtask

    task automatic step(input bit pw, input int src, input bit rdy);
        pc_write        = pw;
        pc_source       = pc_src_t'(src[2:0]);
        fif.fetch_ready = rdy;
        model_edge(pw, src, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_target(input int src, input logic [31:0] val);
        case (src)
            1: jalr   = val;
            2: branch = val;
            3: jal    = val;
            4: mtvec  = val;
            5: mepc   = val;
            default: ;
        endcase
    endtask

    task automatic go(input bit pw, input int src, input logic [31:0] val, input bit rdy);
        set_target(src, val);
        step(pw, src, rdy);
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        rst             = 1'b1;
        pc_write        = 1'b0;
        pc_source       = PLUS4;
        jalr            = 32'h0;
        branch          = 32'h0;
        jal             = 32'h0;
        mtvec           = 32'h80;
        mepc            = 32'h0;
        fif.fetch_ready = 1'b1;
        model_reset();
        #1;
        check("rst_valid", {31'd0, fif.fetch_valid}, 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_bad", bad_target, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_valid", {31'd0, fif.fetch_valid}, 32'd0);

        // Boot cycle then sequential fetches 0,4,8,C.
        step(1, 0, 1);
        check("seq0", fif.fetch_addr, 32'h0);
        check("seq0_valid", {31'd0, fif.fetch_valid}, 32'd1);
        step(1, 0, 1);
        check("seq1", fif.fetch_addr, 32'h4);
        step(1, 0, 1);
        check("seq2", fif.fetch_addr, 32'h8);
        step(1, 0, 1);
        check("seq3", fif.fetch_addr, 32'hC);

        go(1, 3, 32'h100, 1);
        check("jal_100", fif.fetch_addr, 32'h100);
        go(1, 3, 32'h200, 1);
        check("jal_200", fif.fetch_addr, 32'h200);
        go(1, 1, 32'h301, 1);
        check("jalr_lsb", fif.fetch_addr, 32'h300);
        go(1, 5, 32'h44, 1);
        check("mepc", fif.fetch_addr, 32'h44);

        go(1, 2, 32'h102, 1);
        check("mis_pc", pc_o, 32'h80);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("mis_bad", bad_target, 32'h102);
        step(1, 0, 1);
        check("mis_clear", {31'd0, misaligned}, 32'd0);
        check("mis_hold", bad_target, 32'h102);

        go(1, 3, 32'h10, 1);
        go(1, 3, 32'h40, 0);
        check("stall_hold", fif.fetch_addr, 32'h10);
        step(0, 0, 1);
        check("stall_rel", fif.fetch_addr, 32'h40);
        go(1, 3, 32'h50, 0);
        go(1, 3, 32'h60, 0);
        check("stall2_hold", fif.fetch_addr, 32'h40);
        step(0, 0, 1);
        check("last_wins", fif.fetch_addr, 32'h60);

        go(1, 3, 32'hFFFF_FFFC, 1);
        check("wrap_plus4", pc_plus4, 32'h0);
        step(1, 0, 1);
        check("wrap", fif.fetch_addr, 32'h0);

        step(0, 0, 1);
        check("wait_idle", {31'd0, fif.fetch_valid}, 32'd0);
        go(1, 3, 32'h20, 0);
        check("wait_wake", fif.fetch_addr, 32'h20);

        for (int i = 0; i < 400; i++) begin
            int src;
            src = int'($urandom_range(0, 7));
            jalr   = rnd_target();
            branch = rnd_target();
            jal    = rnd_target();
            mepc   = rnd_target();
            mtvec  = {$urandom_range(0, 65535), 2'b00};
            step(($urandom_range(0, 9) < 7), src, ($urandom_range(0, 3) != 0));
        end

        // Reset while a redirect is buffered behind a stalled request.
        go(1, 3, 32'h40, 0);
        go(1, 3, 32'h48, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, fif.fetch_valid}, 32'd0);
        check("mid_rst_pc", pc_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1);
        check("post_rst_addr", fif.fetch_addr, 32'h0);
        step(0, 0, 1);
        check("pend_dropped", {31'd0, fif.fetch_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
